// File: rtl/segre_pkg.sv
// segre_pkg: shared types and constants for the segre core.
//   pipeline_t     execution pipeline targeted by a decoded instruction
//   stall_cause_t  reason the issue scheduler is holding decode
//   wb_resv_t      one register-file write reservation {valid, waddr}
//   *_LAT_DEF      default grant-to-writeback latencies per pipeline
//   resv_hit()     true when a reservation is valid and targets waddr
package segre_pkg;

  localparam int REG_SIZE = 5;

  typedef enum logic [1:0] {
    EX_PIPELINE  = 2'd0,
    MEM_PIPELINE = 2'd1,
    RVM_PIPELINE = 2'd2
  } pipeline_t;

  typedef enum logic [1:0] {
    ST_NONE        = 2'd0,
    ST_WB_CONFLICT = 2'd1,
    ST_MEM_BUSY    = 2'd2
  } stall_cause_t;

  localparam int EX_LAT_DEF  = 1;
  localparam int MEM_LAT_DEF = 3;
  localparam int RVM_LAT_DEF = 5;

  typedef struct packed {
    logic                valid;
    logic [REG_SIZE-1:0] waddr;
  } wb_resv_t;

  function automatic logic resv_hit(input wb_resv_t resv, input logic [REG_SIZE-1:0] waddr);
    return resv.valid && (resv.waddr == waddr);
  endfunction

endpackage

// File: rtl/segre_resv_shiftreg.sv
// segre_resv_shiftreg: reservation shift register for one pipeline.
//   clk_i       clock
//   rsn_i       asynchronous active-high reset, clears every slot
//   shift_en_i  advance the queue by one slot this cycle
//   load_i      reservation entering at the top slot (valid=0 for none)
//   slot_o      registered slots 1..DEPTH-1 (slot k lands k cycles ahead)
//   count_o     number of valid slots, registered with the queue
//
// Slot DEPTH is the landing slot of an instruction granted this cycle.
// Shift-then-load means that entry is already at slot DEPTH-1 when the
// next cycle starts, so slot DEPTH is never stored. Loads are only
// accepted together with a shift; the scheduler never grants into a
// frozen queue.
module segre_resv_shiftreg
  import segre_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             shift_en_i,
  input  wb_resv_t         load_i,
  output wb_resv_t         slot_o [1:DEPTH-1],
  output logic [CNT_W-1:0] count_o
);

  wb_resv_t         slot_q [1:DEPTH-1];
  wb_resv_t         slot_d [1:DEPTH-1];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    slot_d = slot_q;
    if (shift_en_i) begin
      for (int k = 1; k < DEPTH - 1; k++) begin
        slot_d[k] = slot_q[k+1];
      end
      slot_d[DEPTH-1] = load_i;
    end
    count_d = '0;
    for (int k = 1; k < DEPTH; k++) begin
      count_d = count_d + CNT_W'(slot_d[k].valid);
    end
  end

  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      for (int k = 1; k < DEPTH; k++) begin
        slot_q[k] <= '0;
      end
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  assign slot_o  = slot_q;
  assign count_o = count_q;

endmodule

// File: rtl/segre_issue_scheduler.sv
// segre_issue_scheduler: issue gating between decode and EX/MEM/RVM.
//   clk_i             clock
//   rsn_i             asynchronous active-high reset
//   issue_valid_i     decode presents an instruction
//   issue_pipeline_i  target pipeline of that instruction
//   issue_rf_we_i     instruction writes the register file
//   issue_rf_waddr_i  destination register
//   mem_stall_i       MEM pipeline frozen on a cache miss
//   issue_ready_o     instruction may issue this cycle
//   issue_grant_o     issue_valid_i & issue_ready_o
//   stall_cause_o     why issue_ready_o is low (ST_NONE when ready)
//   mem_inflight_o    valid MEM reservations
//   rvm_inflight_o    valid RVM reservations
//
// Every in-flight RF write of MEM and RVM is tracked so that no two
// pipelines ever write back in the same cycle to the same register.
module segre_issue_scheduler
  import segre_pkg::*;
#(
  parameter int EX_LAT  = EX_LAT_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int RVM_LAT = RVM_LAT_DEF
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         issue_valid_i,
  input  pipeline_t                    issue_pipeline_i,
  input  logic                         issue_rf_we_i,
  input  logic [REG_SIZE-1:0]          issue_rf_waddr_i,
  input  logic                         mem_stall_i,
  output logic                         issue_ready_o,
  output logic                         issue_grant_o,
  output stall_cause_t                 stall_cause_o,
  output logic [$clog2(MEM_LAT+1)-1:0] mem_inflight_o,
  output logic [$clog2(RVM_LAT+1)-1:0] rvm_inflight_o
);

  wb_resv_t mem_q [1:MEM_LAT-1];
  wb_resv_t rvm_q [1:RVM_LAT-1];
  wb_resv_t mem_load;
  wb_resv_t rvm_load;

  logic rf_write;
  logic mem_any_hit;
  logic wb_conflict;
  logic mem_busy;

  // x0 writes are discarded by the RF, so they never reserve or collide.
  assign rf_write = issue_rf_we_i && (issue_rf_waddr_i != '0);

  // A pipeline of latency L lands in slot L of the other queues. RVM has
  // the longest latency, so later EX/MEM issues are checked against it
  // rather than the reverse. While MEM is frozen its completion times are
  // unknown, so any match against a held MEM entry counts as a conflict.
  always_comb begin
    wb_conflict = 1'b0;
    mem_busy    = 1'b0;
    mem_any_hit = 1'b0;
    for (int k = 1; k < MEM_LAT; k++) begin
      mem_any_hit = mem_any_hit || resv_hit(mem_q[k], issue_rf_waddr_i);
    end
    case (issue_pipeline_i)
      EX_PIPELINE: begin
        wb_conflict = resv_hit(rvm_q[EX_LAT], issue_rf_waddr_i) ||
                      (!mem_stall_i && resv_hit(mem_q[EX_LAT], issue_rf_waddr_i));
      end
      MEM_PIPELINE: begin
        wb_conflict = resv_hit(rvm_q[MEM_LAT], issue_rf_waddr_i);
        mem_busy    = mem_stall_i;
      end
      default: begin
        wb_conflict = 1'b0;
      end
    endcase
    if (mem_stall_i && mem_any_hit) begin
      wb_conflict = 1'b1;
    end
    wb_conflict = wb_conflict && rf_write;
  end

  always_comb begin
    issue_ready_o = 1'b1;
    stall_cause_o = ST_NONE;
    if (mem_busy) begin
      issue_ready_o = 1'b0;
      stall_cause_o = ST_MEM_BUSY;
    end else if (wb_conflict) begin
      issue_ready_o = 1'b0;
      stall_cause_o = ST_WB_CONFLICT;
    end
  end

  assign issue_grant_o = issue_valid_i && issue_ready_o;

  always_comb begin
    mem_load       = '0;
    rvm_load       = '0;
    mem_load.waddr = issue_rf_waddr_i;
    rvm_load.waddr = issue_rf_waddr_i;
    mem_load.valid = issue_grant_o && rf_write && (issue_pipeline_i == MEM_PIPELINE);
    rvm_load.valid = issue_grant_o && rf_write && (issue_pipeline_i == RVM_PIPELINE);
  end

  segre_resv_shiftreg #(
    .DEPTH(MEM_LAT)
  ) u_mem_resv (
    .clk_i     (clk_i),
    .rsn_i     (rsn_i),
    .shift_en_i(!mem_stall_i),
    .load_i    (mem_load),
    .slot_o    (mem_q),
    .count_o   (mem_inflight_o)
  );

  segre_resv_shiftreg #(
    .DEPTH(RVM_LAT)
  ) u_rvm_resv (
    .clk_i     (clk_i),
    .rsn_i     (rsn_i),
    .shift_en_i(1'b1),
    .load_i    (rvm_load),
    .slot_o    (rvm_q),
    .count_o   (rvm_inflight_o)
  );

endmodule

// File: tb/tb_segre_issue_scheduler.sv
// tb_segre_issue_scheduler: directed bench for segre_issue_scheduler.
// Inputs change just after the falling edge; outputs are sampled 1 ns
// later, well away from the rising edge that updates the queues.
module tb_segre_issue_scheduler;
  import segre_pkg::*;

  logic                clk_i = 1'b0;
  logic                rsn_i;
  logic                issue_valid_i;
  pipeline_t           issue_pipeline_i;
  logic                issue_rf_we_i;
  logic [REG_SIZE-1:0] issue_rf_waddr_i;
  logic                mem_stall_i;
  logic                issue_ready_o;
  logic                issue_grant_o;
  stall_cause_t        stall_cause_o;
  logic [1:0]          mem_inflight_o;
  logic [2:0]          rvm_inflight_o;

  int check_count = 0;
  int error_count = 0;

  always #5 clk_i = ~clk_i;

  segre_issue_scheduler dut (
    .clk_i           (clk_i),
    .rsn_i           (rsn_i),
    .issue_valid_i   (issue_valid_i),
    .issue_pipeline_i(issue_pipeline_i),
    .issue_rf_we_i   (issue_rf_we_i),
    .issue_rf_waddr_i(issue_rf_waddr_i),
    .mem_stall_i     (mem_stall_i),
    .issue_ready_o   (issue_ready_o),
    .issue_grant_o   (issue_grant_o),
    .stall_cause_o   (stall_cause_o),
    .mem_inflight_o  (mem_inflight_o),
    .rvm_inflight_o  (rvm_inflight_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input logic valid, input pipeline_t pipe, input logic we,
                               input int waddr, input logic stall);
    issue_valid_i    = valid;
    issue_pipeline_i = pipe;
    issue_rf_we_i    = we;
    issue_rf_waddr_i = REG_SIZE'(waddr);
    mem_stall_i      = stall;
    #1;
  endtask

  task automatic idle(input logic stall);
    applyStimulus(1'b0, EX_PIPELINE, 1'b0, 0, stall);
  endtask

  task automatic expectIssue(input string tag, input logic ready, input stall_cause_t cause);
    checkOutput({tag, "_ready"}, 32'(issue_ready_o), 32'(ready));
    checkOutput({tag, "_grant"}, 32'(issue_grant_o), 32'(issue_valid_i && ready));
    checkOutput({tag, "_cause"}, 32'(stall_cause_o), 32'(cause));
  endtask

  task automatic expectCounts(input string tag, input int mem_cnt, input int rvm_cnt);
    checkOutput({tag, "_mem_inflight"}, 32'(mem_inflight_o), 32'(mem_cnt));
    checkOutput({tag, "_rvm_inflight"}, 32'(rvm_inflight_o), 32'(rvm_cnt));
  endtask

  initial begin
    rsn_i = 1'b1;
    issue_valid_i = 1'b0;
    issue_pipeline_i = EX_PIPELINE;
    issue_rf_we_i = 1'b0;
    issue_rf_waddr_i = '0;
    mem_stall_i = 1'b0;

    // Reset state
    repeat (2) nextCycle();
    idle(1'b0);
    expectCounts("reset", 0, 0);
    expectIssue("reset_idle", 1'b1, ST_NONE);
    rsn_i = 1'b0;

    // Back-to-back EX writes never reserve
    for (int i = 5; i <= 7; i++) begin
      nextCycle();
      applyStimulus(1'b1, EX_PIPELINE, 1'b1, i, 1'b0);
      expectIssue($sformatf("ex_b2b_x%0d", i), 1'b1, ST_NONE);
    end
    nextCycle();
    idle(1'b0);
    expectCounts("ex_b2b", 0, 0);

    // RVM x5 at t, EX x5 at t+4 collides, EX x6 does not, EX x5 at t+5 ok
    nextCycle();
    applyStimulus(1'b1, RVM_PIPELINE, 1'b1, 5, 1'b0);
    expectIssue("rvm_x5", 1'b1, ST_NONE);
    repeat (3) begin
      nextCycle();
      idle(1'b0);
    end
    expectCounts("rvm_x5_t3", 0, 1);
    nextCycle();
    applyStimulus(1'b1, EX_PIPELINE, 1'b1, 6, 1'b0);
    expectIssue("ex_x6_t4", 1'b1, ST_NONE);
    applyStimulus(1'b1, EX_PIPELINE, 1'b1, 5, 1'b0);
    expectIssue("ex_x5_t4", 1'b0, ST_WB_CONFLICT);
    expectCounts("rvm_x5_t4", 0, 1);
    nextCycle();
    applyStimulus(1'b1, EX_PIPELINE, 1'b1, 5, 1'b0);
    expectIssue("ex_x5_t5", 1'b1, ST_NONE);
    expectCounts("rvm_x5_t5", 0, 0);

    // RVM x9 at t, MEM x9 refused at t+2, granted at t+3
    nextCycle();
    applyStimulus(1'b1, RVM_PIPELINE, 1'b1, 9, 1'b0);
    expectIssue("rvm_x9", 1'b1, ST_NONE);
    nextCycle();
    idle(1'b0);
    nextCycle();
    applyStimulus(1'b1, MEM_PIPELINE, 1'b1, 9, 1'b0);
    expectIssue("mem_x9_t2", 1'b0, ST_WB_CONFLICT);
    nextCycle();
    applyStimulus(1'b1, MEM_PIPELINE, 1'b1, 9, 1'b0);
    expectIssue("mem_x9_t3", 1'b1, ST_NONE);
    nextCycle();
    idle(1'b0);
    expectCounts("mem_x9_t4", 1, 1);
    nextCycle();
    idle(1'b0);
    expectCounts("mem_x9_t5", 1, 0);
    nextCycle();
    idle(1'b0);
    expectCounts("mem_x9_t6", 0, 0);

    // MEM x3 granted, then MEM frozen for four cycles
    nextCycle();
    applyStimulus(1'b1, MEM_PIPELINE, 1'b1, 3, 1'b0);
    expectIssue("mem_x3", 1'b1, ST_NONE);
    nextCycle();
    applyStimulus(1'b1, EX_PIPELINE, 1'b1, 3, 1'b1);
    expectIssue("stall_ex_x3", 1'b0, ST_WB_CONFLICT);
    expectCounts("stall_1", 1, 0);
    nextCycle();
    applyStimulus(1'b1, EX_PIPELINE, 1'b1, 4, 1'b1);
    expectIssue("stall_ex_x4", 1'b1, ST_NONE);
    nextCycle();
    applyStimulus(1'b1, MEM_PIPELINE, 1'b1, 3, 1'b1);
    expectIssue("stall_mem_x3", 1'b0, ST_MEM_BUSY);
    applyStimulus(1'b1, MEM_PIPELINE, 1'b1, 8, 1'b1);
    expectIssue("stall_mem_x8", 1'b0, ST_MEM_BUSY);
    nextCycle();
    applyStimulus(1'b0, MEM_PIPELINE, 1'b1, 8, 1'b1);
    expectIssue("stall_mem_novalid", 1'b0, ST_MEM_BUSY);
    expectCounts("stall_4", 1, 0);
    nextCycle();
    idle(1'b0);
    expectCounts("release_0", 1, 0);
    nextCycle();
    applyStimulus(1'b1, EX_PIPELINE, 1'b1, 3, 1'b0);
    expectIssue("release_ex_x3", 1'b0, ST_WB_CONFLICT);
    expectCounts("release_1", 1, 0);
    nextCycle();
    applyStimulus(1'b1, EX_PIPELINE, 1'b1, 3, 1'b0);
    expectIssue("release_ex_x3_ok", 1'b1, ST_NONE);
    expectCounts("release_2", 0, 0);

    // Writes to x0 never reserve nor conflict
    nextCycle();
    applyStimulus(1'b1, RVM_PIPELINE, 1'b1, 0, 1'b0);
    expectIssue("rvm_x0", 1'b1, ST_NONE);
    repeat (3) begin
      nextCycle();
      idle(1'b0);
      expectCounts("rvm_x0_wait", 0, 0);
    end
    nextCycle();
    applyStimulus(1'b1, EX_PIPELINE, 1'b1, 0, 1'b0);
    expectIssue("ex_x0", 1'b1, ST_NONE);

    // Fill the RVM queue, then reset asynchronously mid-cycle
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      applyStimulus(1'b1, RVM_PIPELINE, 1'b1, 10 + i, 1'b0);
      expectIssue($sformatf("rvm_fill_%0d", i), 1'b1, ST_NONE);
    end
    expectCounts("rvm_full", 0, 4);
    applyStimulus(1'b1, EX_PIPELINE, 1'b1, 10, 1'b0);
    expectIssue("ex_x10_prereset", 1'b0, ST_WB_CONFLICT);
    rsn_i = 1'b1;
    #1;
    expectCounts("async_reset", 0, 0);
    expectIssue("ex_x10_reset", 1'b1, ST_NONE);
    applyStimulus(1'b1, MEM_PIPELINE, 1'b1, 3, 1'b1);
    expectIssue("reset_stall_mem", 1'b0, ST_MEM_BUSY);
    applyStimulus(1'b1, RVM_PIPELINE, 1'b1, 12, 1'b1);
    expectIssue("reset_stall_rvm", 1'b1, ST_NONE);
    nextCycle();
    rsn_i = 1'b0;
    idle(1'b0);
    expectCounts("post_reset", 0, 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
